// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: adds two WIDTH-bit operands one nibble per cycle through an external 4-bit adder slice
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_r, sum_nx;
  logic carry, cout_r, run, last, accept;
  assign run = state == RUN;
  assign last = run && cnt == LAST;
  assign in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
  assign accept = in_valid && in_ready;
  assign add_a = run ? a_sh[3:0] : 4'd0;
  assign add_b = run ? b_sh[3:0] : 4'd0;
  assign add_cin = run && carry;
  assign sum_nx = WIDTH'({add_sum, sum_sh} >> 4);
  assign out_valid = state == DONE;
  assign out_sum = sum_r;
  assign out_cout = cout_r;
  always_comb state_nx = accept ? RUN : last ? DONE : (out_valid && out_ready) ? IDLE : state;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // sum_r is the visible result so it holds steady while the next op shifts sum_sh
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      a_sh <= '0;
      b_sh <= '0;
      carry <= 1'b0;
      sum_sh <= '0;
      sum_r <= '0;
      cout_r <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      a_sh <= in_a;
      b_sh <= in_b;
      carry <= in_cin;
      sum_sh <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      a_sh <= a_sh >> 4;
      b_sh <= b_sh >> 4;
      carry <= add_cout;
      sum_sh <= sum_nx;
      if (last) begin
        sum_r <= sum_nx;
        cout_r <= add_cout;
      end
    end
  end
endmodule
